// File: rtl/hififo_pkg.sv
// Shared types and constants for the FPC read-request generator.
// Widths are fixed by the PCIe request format: 61-bit word address, 55-bit block address, 3-bit tag.
package hififo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BLOCK_BYTES      = 512;
    localparam int BLOCK_WORDS_LOG2 = 6;
    localparam int TAG_W            = 3;
    localparam int ADDR_W           = 61;
    localparam int ADDR_BLK_W       = ADDR_W - BLOCK_WORDS_LOG2;
    localparam int COUNT_W          = 19;

endpackage

// File: rtl/hififo_tag_pool.sv
// Free-tag pool: lowest-index allocation, release on completion, sticky bad-release flag.
// Latency: release visible in the free mask after one edge; allocation uses the registered mask.
// Backpressure: none; caller only allocates while any_free is high.
module hififo_tag_pool
    import hififo_pkg::*;
#(
    parameter int NTAGS = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             alloc,
    input  logic             rel_valid,
    input  logic [TAG_W-1:0] rel_tag,
    output logic [TAG_W-1:0] free_tag,
    output logic             any_free,
    output logic             full_next,
    output logic             err_release
);

    logic [NTAGS-1:0] free_q;
    logic [NTAGS-1:0] free_d;
    logic [NTAGS-1:0] rel_req;
    logic [NTAGS-1:0] rel_hot;
    logic [NTAGS-1:0] alloc_hot;
    logic             rel_bad;

    always_comb begin
        free_tag = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (free_q[i]) free_tag = TAG_W'(i);
        end
    end

    // Out-of-range tags decode to nothing, so they fall out as a bad release.
    always_comb begin
        rel_req = '0;
        if (rel_valid && (32'(rel_tag) < NTAGS)) rel_req = NTAGS'(1) << rel_tag;
    end

    assign rel_hot   = rel_req & ~free_q;
    assign rel_bad   = rel_valid && (rel_hot == '0);
    assign alloc_hot = alloc ? (NTAGS'(1) << free_tag) : '0;
    assign free_d    = (free_q | rel_hot) & ~alloc_hot;
    assign any_free  = |free_q;
    assign full_next = &free_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            free_q      <= '1;
            err_release <= 1'b0;
        end else begin
            free_q      <= free_d;
            err_release <= err_release | rel_bad;
        end
    end

endmodule

// File: rtl/hififo_rr_gen.sv
// Read-request generator: splits host descriptors into 512-byte tagged reads (HIFIFO_RR_STATS_EN adds counters).
// Latency: accept to first rr_valid 2 cycles, then 1 request/cycle; last release to interrupt 1 cycle.
// Backpressure: rr_valid/addr/tag hold until rr_ready; stalls with rr_valid low when no tag is free.
module hififo_rr_gen
    import hififo_pkg::*;
#(
    parameter  int NTAGS            = 8,
    parameter  int BLOCK_WORDS_LOG2 = hififo_pkg::BLOCK_WORDS_LOG2,
    localparam int BLK_W            = ADDR_W - BLOCK_WORDS_LOG2,
    localparam int CNT_W            = COUNT_W - BLOCK_WORDS_LOG2 + 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               r_valid,
    input  logic [ADDR_W-1:0]  r_addr,
    input  logic [COUNT_W-1:0] r_count,
    input  logic               r_interrupt,
    output logic               r_ready,
    output logic               rr_valid,
    output logic [BLK_W-1:0]   rr_addr,
    output logic [TAG_W-1:0]   rr_tag_low,
    input  logic               rr_ready,
    input  logic               rel_valid,
    input  logic [TAG_W-1:0]   rel_tag,
    output logic               interrupt,
    output logic               busy,
    output logic               err_release
`ifdef HIFIFO_RR_STATS_EN
    ,
    output logic [31:0]        stat_blocks,
    output logic [31:0]        stat_tag_stall
`endif
);

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               hs;
    logic               alloc;
    logic               rr_valid_d;
    logic               irq_d;
    logic               irq_flag_q;
    logic [CNT_W-1:0]   rem_q;
    logic [CNT_W-1:0]   blocks;
    logic [BLK_W-1:0]   blk_addr;
    logic [TAG_W-1:0]   free_tag;
    logic               any_free;
    logic               full_next;
    logic               unused_addr_lo;

    assign accept = r_valid && r_ready;
    assign hs     = rr_valid && rr_ready;

    // Word count rounded up to whole blocks; one spare bit so a maximal count cannot wrap to zero.
    assign blocks   = CNT_W'(r_count >> BLOCK_WORDS_LOG2)
                    + CNT_W'(|r_count[BLOCK_WORDS_LOG2-1:0]);
    assign blk_addr = r_addr[ADDR_W-1:BLOCK_WORDS_LOG2];
    assign unused_addr_lo = ^r_addr[BLOCK_WORDS_LOG2-1:0];

    hififo_tag_pool #(
        .NTAGS (NTAGS)
    ) u_tag_pool (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc       (alloc),
        .rel_valid   (rel_valid),
        .rel_tag     (rel_tag),
        .free_tag    (free_tag),
        .any_free    (any_free),
        .full_next   (full_next),
        .err_release (err_release)
    );

    always_comb begin
        state_d    = state_q;
        alloc      = 1'b0;
        rr_valid_d = rr_valid;
        irq_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = (blocks == '0) ? ST_DRAIN : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (hs) rr_valid_d = 1'b0;
                if (hs && (rem_q == CNT_W'(1))) begin
                    state_d = ST_DRAIN;
                end else if ((!rr_valid || hs) && any_free) begin
                    // Reloading on the handshake keeps back-to-back issue at one per cycle.
                    alloc      = 1'b1;
                    rr_valid_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!irq_flag_q) begin
                    state_d = ST_IDLE;
                end else if (full_next) begin
                    irq_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            r_ready    <= 1'b0;
            rr_valid   <= 1'b0;
            rr_addr    <= '0;
            rr_tag_low <= '0;
            rem_q      <= '0;
            irq_flag_q <= 1'b0;
            interrupt  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_valid  <= rr_valid_d;
            interrupt <= irq_d;
            r_ready   <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE) || !full_next;
            if (accept) begin
                rr_addr    <= blk_addr;
                rem_q      <= blocks;
                irq_flag_q <= r_interrupt;
            end else if (hs) begin
                rr_addr <= rr_addr + BLK_W'(1);
                rem_q   <= rem_q - CNT_W'(1);
            end
            if (alloc) rr_tag_low <= free_tag;
        end
    end

`ifdef HIFIFO_RR_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_blocks    <= '0;
            stat_tag_stall <= '0;
        end else begin
            if (hs) stat_blocks <= stat_blocks + 32'd1;
            if ((state_q == ST_ISSUE) && !any_free && (stat_tag_stall != '1))
                stat_tag_stall <= stat_tag_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hififo_rr_gen.sv
// Directed bench for hififo_rr_gen: expected requests queued by stimulus, popped by a negedge monitor.
module tb_hififo_rr_gen;

    typedef struct packed {
        logic [54:0] addr;
        logic [2:0]  tag;
    } req_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        r_valid;
    logic [60:0] r_addr;
    logic [18:0] r_count;
    logic        r_interrupt;
    logic        r_ready;
    logic        rr_valid;
    logic [54:0] rr_addr;
    logic [2:0]  rr_tag_low;
    logic        rr_ready;
    logic        rel_valid;
    logic [2:0]  rel_tag;
    logic        interrupt;
    logic        busy;
    logic        err_release;
`ifdef HIFIFO_RR_STATS_EN
    logic [31:0] stat_blocks;
    logic [31:0] stat_tag_stall;
`endif

    int   checks = 0;
    int   fails  = 0;
    int   hs_cnt = 0;
    int   irq_cnt = 0;
    int   base;
    int   irq0;
    req_t exp_q[$];
    req_t mon_e;

    always #5 clock = ~clock;

    hififo_rr_gen dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .r_valid     (r_valid),
        .r_addr      (r_addr),
        .r_count     (r_count),
        .r_interrupt (r_interrupt),
        .r_ready     (r_ready),
        .rr_valid    (rr_valid),
        .rr_addr     (rr_addr),
        .rr_tag_low  (rr_tag_low),
        .rr_ready    (rr_ready),
        .rel_valid   (rel_valid),
        .rel_tag     (rel_tag),
        .interrupt   (interrupt),
        .busy        (busy),
        .err_release (err_release)
`ifdef HIFIFO_RR_STATS_EN
        ,
        .stat_blocks    (stat_blocks),
        .stat_tag_stall (stat_tag_stall)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (interrupt) irq_cnt++;
            if (rr_valid && rr_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL rr_unexpected: got addr %0h tag %0d, expected no request", rr_addr, rr_tag_low);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rr_addr", 64'(rr_addr), 64'(mon_e.addr));
                    chk("rr_tag_low", 64'(rr_tag_low), 64'(mon_e.tag));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [54:0] a, input logic [2:0] t);
        req_t e;
        e.addr = a;
        e.tag  = t;
        exp_q.push_back(e);
    endtask

    task automatic send_desc(input logic [60:0] a, input logic [18:0] c, input logic irq);
        logic ok;
        ok          = 1'b0;
        r_addr      = a;
        r_count     = c;
        r_interrupt = irq;
        r_valid     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (r_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("desc_accept", 64'(ok), 64'(1));
        @(posedge clock);
        #1;
        r_valid = 1'b0;
    endtask

    task automatic release_tag(input logic [2:0] t);
        rel_valid = 1'b1;
        rel_tag   = t;
        tick();
        rel_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            if (hs_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        chk("hs_wait", 64'(ok), 64'(1));
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, "_rr_valid"}, 64'(rr_valid), 64'(0));
        chk({tagname, "_rr_addr"}, 64'(rr_addr), 64'(0));
        chk({tagname, "_rr_tag"}, 64'(rr_tag_low), 64'(0));
        chk({tagname, "_interrupt"}, 64'(interrupt), 64'(0));
        chk({tagname, "_busy"}, 64'(busy), 64'(0));
        chk({tagname, "_err"}, 64'(err_release), 64'(0));
        chk({tagname, "_r_ready"}, 64'(r_ready), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] pat;
        logic [2:0] reissue [7];
        reissue = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        pat = 6'b011110;

        reset_n = 1'b0; r_valid = 1'b0; r_addr = '0; r_count = '0; r_interrupt = 1'b0;
        rr_ready = 1'b0; rel_valid = 1'b0; rel_tag = '0;
        repeat (3) tick();
        @(negedge clock);
        chk_reset_outputs("rst");
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        chk("r_ready_after_deassert", 64'(r_ready), 64'(0));
        tick();
        @(negedge clock);
        chk("r_ready_idle", 64'(r_ready), 64'(1));
        tick();

        // 4 blocks back to back, first request two cycles after accept
        rr_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(55'h40 + 55'(i), 3'(i));
        send_desc(61'h1000, 19'd256, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("t1_rr_valid_timing", 64'(rr_valid), 64'(pat[i]));
        end
        tick();
        for (int t = 0; t < 4; t++) release_tag(3'(t));
        tick();
        @(negedge clock);
        chk("t1_busy_clear", 64'(busy), 64'(0));
        chk("t1_queue_empty", 64'(exp_q.size()), 64'(0));
        tick();

        // 16 blocks with only 8 tags, interrupt at the end
        base = hs_cnt;
        irq0 = irq_cnt;
        for (int i = 0; i < 8; i++) push(55'h80 + 55'(i), 3'(i));
        send_desc(61'h2000, 19'd1000, 1'b1);
        wait_hs(base + 8);
        repeat (5) tick();
        @(negedge clock);
        chk("t2_stall_valid", 64'(rr_valid), 64'(0));
        chk("t2_stall_busy", 64'(busy), 64'(1));
        tick();
        push(55'h88, 3'd3);
        release_tag(3'd3);
        @(negedge clock);
        chk("t2_realloc_gap", 64'(rr_valid), 64'(0));
        @(negedge clock);
        chk("t2_realloc_valid", 64'(rr_valid), 64'(1));
        chk("t2_realloc_tag", 64'(rr_tag_low), 64'(3));
        wait_hs(base + 9);
        for (int j = 0; j < 7; j++) begin
            push(55'h89 + 55'(j), reissue[j]);
            release_tag(reissue[j]);
            wait_hs(base + 10 + j);
        end
        tick();
        for (int t = 0; t < 7; t++) release_tag(3'(t));
        chk("t2_no_early_irq", 64'(irq_cnt), 64'(irq0));
        release_tag(3'd7);
        @(negedge clock);
        chk("t2_irq_pulse", 64'(interrupt), 64'(1));
        @(negedge clock);
        chk("t2_irq_width", 64'(interrupt), 64'(0));
        chk("t2_irq_count", 64'(irq_cnt), 64'(irq0 + 1));
        chk("t2_queue_empty", 64'(exp_q.size()), 64'(0));
        tick();

        // rr_ready held low: request must stay stable
        rr_ready = 1'b0;
        base = hs_cnt;
        push(55'hC0, 3'd0);
        push(55'hC1, 3'd1);
        send_desc(61'h3000, 19'd128, 1'b0);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t3_hold_valid", 64'(rr_valid), 64'(1));
            chk("t3_hold_addr", 64'(rr_addr), 64'h0C0);
            chk("t3_hold_tag", 64'(rr_tag_low), 64'(0));
        end
        tick();
        rr_ready = 1'b1;
        tick();
        rr_ready = 1'b0;
        @(negedge clock);
        chk("t3_one_consumed", 64'(hs_cnt), 64'(base + 1));
        chk("t3_next_addr", 64'(rr_addr), 64'h0C1);
        chk("t3_next_tag", 64'(rr_tag_low), 64'(1));
        tick();
        rr_ready = 1'b1;
        wait_hs(base + 2);
        release_tag(3'd0);
        release_tag(3'd1);

        // block address wraps at 2^55
        base = hs_cnt;
        push(55'h7F_FFFF_FFFF_FFFF, 3'd0);
        push(55'h0, 3'd1);
        send_desc(61'h1FFF_FFFF_FFFF_FFC0, 19'd128, 1'b0);
        wait_hs(base + 2);
        release_tag(3'd0);
        release_tag(3'd1);
        tick();

        // zero-length descriptor with interrupt, then a bad release
        irq0 = irq_cnt;
        send_desc(61'h6000, 19'd0, 1'b1);
        @(negedge clock);
        chk("t5_irq_c1", 64'(interrupt), 64'(0));
        chk("t5_no_request", 64'(rr_valid), 64'(0));
        @(negedge clock);
        chk("t5_irq_c2", 64'(interrupt), 64'(1));
        @(negedge clock);
        chk("t5_irq_c3", 64'(interrupt), 64'(0));
        chk("t5_r_ready", 64'(r_ready), 64'(1));
        chk("t5_irq_count", 64'(irq_cnt), 64'(irq0 + 1));
        tick();
        chk("t5_err_before", 64'(err_release), 64'(0));
        release_tag(3'd5);
        @(negedge clock);
        chk("t5_err_set", 64'(err_release), 64'(1));
        repeat (3) tick();
        @(negedge clock);
        chk("t5_err_sticky", 64'(err_release), 64'(1));
        chk("t5_busy", 64'(busy), 64'(0));
        tick();

        // reset in the middle of ISSUE with tags outstanding
        base = hs_cnt;
        for (int i = 0; i < 5; i++) push(55'h100 + 55'(i), 3'(i));
        send_desc(61'h4000, 19'd640, 1'b0);
        wait_hs(base + 5);
        rr_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        chk("t6_queue_empty", 64'(exp_q.size()), 64'(0));
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        base = hs_cnt;
        rr_ready = 1'b1;
        push(55'h140, 3'd0);
        send_desc(61'h5000, 19'd64, 1'b0);
        wait_hs(base + 1);
        release_tag(3'd0);
        tick();
        @(negedge clock);
        chk("t6_busy_clear", 64'(busy), 64'(0));
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("final_irq_total", 64'(irq_cnt), 64'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
